// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - execute-stage multiply/divide unit with architectural HI/LO
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by defining MDU_MADD_EN.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load, finish, accept;
   logic             is_mult_class, is_div_class;

   logic [31:0] pend_hi, pend_lo;
   logic        pend_ok;
   logic [31:0] res_hi, res_lo;
   logic        res_ok;

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_abs, b_abs, b_safe, q_mag, r_mag;
   logic [31:0] uq, ur, urt_safe;
   logic        div_zero;

   assign busy   = (state_q == RUN);
   assign accept = (state_q == IDLE) && start;

   always_comb begin
      is_mult_class = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mult_class = is_mult_class || (op == OP_MADD) || (op == OP_MADDU) ||
                      (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      is_div_class  = (op == OP_DIV) || (op == OP_DIVU);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && (is_mult_class || is_div_class)) begin
               state_d = RUN;
               cnt_d   = is_div_class ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               load    = 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               finish  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
      div_zero = (rt_val == 32'd0);
      a_abs    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
      b_abs    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
      b_safe   = div_zero ? 32'd1 : b_abs;
      q_mag    = a_abs / b_safe;
      r_mag    = a_abs % b_safe;
      urt_safe = div_zero ? 32'd1 : rt_val;
      uq       = rs_val / urt_safe;
      ur       = rs_val % urt_safe;
   end

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_ok = 1'b1;
      case (op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_ok = !div_zero;
            res_lo = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
            res_hi = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
         end
         OP_DIVU: begin
            res_ok = !div_zero;
            res_lo = uq;
            res_hi = ur;
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
         OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
         OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
         OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
         default:  res_ok = 1'b0;
      endcase
   end

   // hi/lo only move on completion or mthi/mtlo; no bypass of the pending result.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_ok <= 1'b0;
      end else begin
         if (load) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_ok <= res_ok;
         end
         if (finish && pend_ok) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (accept && (op == OP_MTHI)) hi <= rs_val;
         if (accept && (op == OP_MTLO)) lo <= rs_val;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%08h exp=00000000", hi); end
      checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%08h exp=00000000", lo); end
   endtask

   task automatic test_mult;
      int n;
      issue(4'd1, 32'hFFFFFFFE, 32'd3);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_now got=%0h exp=1", busy); end
      checks++; if (lo !== 32'd0) begin failures++; $display("FAIL mult_no_bypass got=%08h exp=00000000", lo); end
      wait_idle(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%08h exp=FFFFFFFF", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%08h exp=FFFFFFFA", lo); end
   endtask

   task automatic test_multu;
      int n;
      issue(4'd2, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%08h exp=00000001", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%08h exp=FFFFFFFE", lo); end
   endtask

   task automatic test_div;
      int n;
      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
      checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%08h exp=FFFFFFFD", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%08h exp=FFFFFFFF", hi); end
      issue(4'd4, 32'd7, 32'd0);
      wait_idle(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL divu0_busy_cycles got=%0d exp=10", n); end
      checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divu0_lo got=%08h exp=FFFFFFFD", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_hi got=%08h exp=FFFFFFFF", hi); end
      issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%08h exp=80000000", lo); end
      checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%08h exp=00000000", hi); end
      issue(4'd4, 32'd100, 32'd7);
      wait_idle(n);
      checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%08h exp=0000000E", lo); end
      checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%08h exp=00000002", hi); end
   endtask

   task automatic test_mthi;
      int n;
      issue(4'd4, 32'd7, 32'd0);
      start = 1'b1; op = 4'd5; rs_val = 32'h12345678;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      wait_idle(n);
      checks++; if (hi !== 32'd2) begin failures++; $display("FAIL mthi_busy_ignored got=%08h exp=00000002", hi); end
      issue(4'd5, 32'h12345678, 32'd0);
      checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_idle got=%08h exp=12345678", hi); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_no_busy got=%0h exp=0", busy); end
      issue(4'd6, 32'hCAFEF00D, 32'd0);
      checks++; if (lo !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_idle got=%08h exp=CAFEF00D", lo); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(4'd1, 32'h00010000, 32'h00010000);
      wait_idle(n);
      start = 1'b1; op = 4'd2; rs_val = 32'h80000000; rt_val = 32'h80000000;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%0h exp=1", busy); end
      checks++; if (hi !== 32'd1 || lo !== 32'd0) begin failures++; $display("FAIL b2b_first got=%08h_%08h exp=00000001_00000000", hi, lo); end
      wait_idle(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'h40000000 || lo !== 32'd0) begin failures++; $display("FAIL b2b_second got=%08h_%08h exp=40000000_00000000", hi, lo); end
   endtask

   task automatic test_reset_mid;
      int n;
      issue(4'd4, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%08h_%08h exp=00000000_00000000", hi, lo); end
      repeat (15) @(negedge clk);
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_no_land got=%08h_%08h exp=00000000_00000000", hi, lo); end
      wait_idle(n);
   endtask

   task automatic test_madd;
      int n;
      issue(4'd5, 32'd0, 32'd0);
      issue(4'd6, 32'hFFFFFFFF, 32'd0);
      issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL maddu_busy got=%0h exp=1", busy); end
      wait_idle(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL maddu_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'd1 || lo !== 32'd0) begin failures++; $display("FAIL maddu_result got=%08h_%08h exp=00000001_00000000", hi, lo); end
      issue(4'd9, 32'hFFFFFFFF, 32'd1);
      wait_idle(n);
      checks++; if (hi !== 32'd1 || lo !== 32'd1) begin failures++; $display("FAIL msub_result got=%08h_%08h exp=00000001_00000001", hi, lo); end
`else
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL maddu_off_busy got=%0h exp=0", busy); end
      wait_idle(n);
      checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL maddu_off_hilo got=%08h_%08h exp=00000000_FFFFFFFF", hi, lo); end
`endif
      issue(4'd15, 32'hDEADBEEF, 32'd3);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL op15_busy got=%0h exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_mthi();
      test_back_to_back();
      test_reset_mid();
      test_madd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
